writeback_arbiter: RTL and testbench
====================================

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 The block SHALL have parameter THREADS_PER_WARP, default 32, meaning lanes per warp.
REQ-002 The block SHALL have parameter NUM_WARPS, default 32, meaning resident warps.
REQ-003 The block SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive ALU losses before forced ALU grant.
REQ-004 The block SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-005 The block SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-006 The block SHALL have ports alu_valid in 1, alu_ready out 1, alu_warp_id in 6, alu_rd in 5, alu_mask in 32, alu_data in 32 x THREADS_PER_WARP: ALU result channel.
REQ-007 The block SHALL have ports mem_valid in 1, mem_ready out 1, mem_warp_id in 6, mem_rd in 5, mem_mask in 32, mem_data in 32 x THREADS_PER_WARP: load-return channel.
REQ-008 The block SHALL have outputs rd_write_en 1, rd_warp_id 6, rd_addr 5, rd_thread_mask 32, rd_data 32 x THREADS_PER_WARP: register-file write port.
REQ-009 The block SHALL have outputs clear_busy_en 1, clear_busy_warp 6, clear_busy_reg 5: scoreboard release.
REQ-010 The block SHALL have outputs alu_wb_count 32 and mem_wb_count 32: retired-writeback counters.

Function
REQ-011 A channel transfer SHALL occur on a rising edge where valid and ready are both high.
REQ-012 MEM transfers SHALL enter a 2-entry FIFO; mem_ready SHALL be high iff the FIFO holds fewer than 2 entries, evaluated from registered occupancy, so a full FIFO refuses a push even in a cycle it pops.
REQ-013 The ALU channel SHALL be unbuffered; alu_ready SHALL be high iff the ALU wins arbitration that cycle, combinationally.
REQ-014 Arbitration SHALL consider the FIFO head and alu_valid; MEM head SHALL win by default.
REQ-015 A starve counter SHALL increment each cycle alu_valid is high and the ALU loses, reset to 0 on ALU grant, and saturate at STARVE_LIMIT.
REQ-016 When the starve counter equals STARVE_LIMIT and alu_valid is high, the ALU SHALL win over a non-empty FIFO.
REQ-017 A request granted in cycle N SHALL appear on the write and scoreboard outputs in cycle N+1 for exactly one cycle; at most one grant per cycle.
REQ-018 rd_write_en SHALL be 1 only if the granted rd is nonzero and mask is nonzero; rd fields, mask and data SHALL still be driven.
REQ-019 clear_busy_en SHALL be 1 for every grant, including rd = 0 or zero mask, with clear_busy_warp/reg equal to granted warp_id/rd.
REQ-020 With no grant, rd_write_en and clear_busy_en SHALL be 0 and data fields SHALL hold their previous values.
REQ-021 An empty FIFO pushed in cycle N SHALL make its head eligible for arbitration in cycle N+1.
REQ-022 alu_wb_count/mem_wb_count SHALL increment by 1 per granted request of that source, wrapping modulo 2^32.
REQ-023 FIFO pointers SHALL wrap modulo 2; simultaneous push and pop with 1 entry SHALL leave occupancy 1.

Reset
REQ-024 While rst is high, FIFO occupancy, pointers, starve counter and both count outputs SHALL be 0.
REQ-025 While rst is high, rd_write_en, clear_busy_en, alu_ready SHALL be 0, mem_ready SHALL be 0, and all rd/clear field outputs SHALL be 0.
REQ-026 Reset asserted mid-operation SHALL discard FIFO contents and any pending output with no write issued; mem_ready SHALL rise on the first edge after rst falls.

Structure
REQ-027 Package wb_types SHALL hold typedef wb_req_t (warp_id 6, rd 5, mask 32, data array) and constant WB_FIFO_DEPTH = 2.
REQ-028 The MEM buffer SHALL be sub-module wb_fifo (wb_req_t entries, push/pop/full/empty, active-high async reset); arbitration and output register SHALL live in writeback_arbiter.

Verification
REQ-029 ALU only: warp 3, rd 7, mask 0xFFFFFFFF, data lane i = i -> next cycle rd_write_en=1, rd_addr=7, rd_data[5]=5, clear_busy_en=1, alu_wb_count=1.
REQ-030 MEM and ALU both valid every cycle for 6 cycles -> grants M,M,M,M,A,M pattern: ALU granted on 5th cycle; starve counter returns to 0.
REQ-031 Three MEM pushes with no ALU and write side stalled by a continuous ALU-forced grant -> mem_ready=0 after 2 entries; third accepted only after a pop.
REQ-032 ALU grant rd=0, mask 0xFF -> rd_write_en=0, clear_busy_en=1, clear_busy_reg=0; mask 0 on rd=4 -> rd_write_en=0, clear_busy_en=1.
REQ-033 FIFO holding 2 entries, rst pulsed one cycle -> no write pulses follow, counters 0, mem_ready=1 one edge after rst falls.

Source files
------------

// File: rtl/wb_types.sv
// Shared types for the writeback arbiter.
//
// wb_req_t carries one warp-wide register writeback: destination warp,
// destination register, per-lane write mask and one 32-bit word per lane.
// The data array is sized for the widest warp the arbiter supports.
// Narrower warps leave the upper lanes zero.
package wb_types;

    localparam int WB_FIFO_DEPTH = 2;
    localparam int WB_MAX_LANES  = 32;
    localparam int WB_WARP_W     = 6;
    localparam int WB_REG_W      = 5;
    localparam int WB_MASK_W     = 32;
    localparam int WB_WORD_W     = 32;

    typedef logic [WB_MAX_LANES-1:0][WB_WORD_W-1:0] wb_data_t;

    typedef struct packed {
        logic [WB_WARP_W-1:0] warp_id;
        logic [WB_REG_W-1:0]  rd;
        logic [WB_MASK_W-1:0] mask;
        wb_data_t             data;
    } wb_req_t;

    // r0 is hardwired and an empty mask touches no lane. Neither case writes
    // the register file, but both still release the scoreboard entry.
    function automatic logic wb_writes_reg(input wb_req_t req);
        return (req.rd != '0) && (req.mask != '0);
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small FIFO of wb_req_t entries that buffers load returns.
//
// Ports:
//   clk, rst   clock; asynchronous active-high reset (clears pointers/occupancy)
//   push       write push_req at the tail (ignored while full)
//   push_req   entry to write
//   pop        drop the head entry (ignored while empty)
//   head       current head entry (valid only while !empty)
//   full       occupancy == WB_FIFO_DEPTH, from registered occupancy
//   empty      occupancy == 0, from registered occupancy
//
// Full is taken from the registered count. A full FIFO therefore refuses a
// push even in a cycle where it also pops.
module wb_fifo
    import wb_types::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  wb_req_t push_req,
    input  logic    pop,
    output wb_req_t head,
    output logic    full,
    output logic    empty
);

    localparam int PTR_W = (WB_FIFO_DEPTH > 1) ? $clog2(WB_FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(WB_FIFO_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(WB_FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(WB_FIFO_DEPTH);

    wb_req_t          entries [WB_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = entries[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset. Entries are only observed through
    // pointers, and the pointers are reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            entries[wr_ptr] <= push_req;
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges ALU results and load returns into the single
// register-file write port and releases the matching scoreboard entry.
//
// Ports:
//   clk, rst                    clock; asynchronous active-high reset
//   alu_valid/alu_ready         ALU result channel (unbuffered)
//   alu_warp_id/rd/mask/data    ALU result payload
//   mem_valid/mem_ready         load-return channel (into a 2-entry FIFO)
//   mem_warp_id/rd/mask/data    load-return payload
//   rd_write_en, rd_warp_id, rd_addr, rd_thread_mask, rd_data
//                               registered register-file write port
//   clear_busy_en/_warp/_reg    registered scoreboard release
//   alu_wb_count, mem_wb_count  granted writebacks per source (wrap 2^32)
//
// Handshake: a channel transfers on a rising edge where its valid and ready
// are both high. A producer holds valid and payload until it sees ready.
// ready never depends on a transfer completing in the same cycle, except
// that alu_ready is the combinational ALU grant.
//
// Arbitration: the MEM FIFO head wins by default. The ALU wins when the FIFO
// is empty. It also wins after STARVE_LIMIT consecutive losses. A grant in
// cycle N appears on the write and scoreboard outputs in cycle N+1.
module writeback_arbiter
    import wb_types::*;
#(
    parameter int THREADS_PER_WARP = 32,
    parameter int NUM_WARPS        = 32,
    parameter int STARVE_LIMIT     = 4
) (
    input  logic                              clk,
    input  logic                              rst,

    input  logic                              alu_valid,
    output logic                              alu_ready,
    input  logic [5:0]                        alu_warp_id,
    input  logic [4:0]                        alu_rd,
    input  logic [31:0]                       alu_mask,
    input  logic [THREADS_PER_WARP-1:0][31:0] alu_data,

    input  logic                              mem_valid,
    output logic                              mem_ready,
    input  logic [5:0]                        mem_warp_id,
    input  logic [4:0]                        mem_rd,
    input  logic [31:0]                       mem_mask,
    input  logic [THREADS_PER_WARP-1:0][31:0] mem_data,

    output logic                              rd_write_en,
    output logic [5:0]                        rd_warp_id,
    output logic [4:0]                        rd_addr,
    output logic [31:0]                       rd_thread_mask,
    output logic [THREADS_PER_WARP-1:0][31:0] rd_data,

    output logic                              clear_busy_en,
    output logic [5:0]                        clear_busy_warp,
    output logic [4:0]                        clear_busy_reg,

    output logic [31:0]                       alu_wb_count,
    output logic [31:0]                       mem_wb_count
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    // Elaboration-time guards on parameters the fixed-width ports rely on.
    if (THREADS_PER_WARP < 1 || THREADS_PER_WARP > WB_MAX_LANES) begin : g_lane_check
        $error("THREADS_PER_WARP out of range for wb_req_t");
    end
    if (NUM_WARPS < 1 || NUM_WARPS > (1 << WB_WARP_W)) begin : g_warp_check
        $error("NUM_WARPS does not fit the warp_id field");
    end

    // Low after reset until the first clock edge. This keeps both readies
    // and all grants off until that edge.
    logic                run;
    logic [STARVE_W-1:0] starve_cnt;

    wb_req_t alu_req;
    wb_req_t mem_req;
    wb_req_t fifo_head;
    wb_req_t win_req;
    wb_data_t rd_data_q;

    logic fifo_full;
    logic fifo_empty;
    logic alu_force;
    logic grant_alu;
    logic grant_mem;
    logic mem_push;

    always_comb begin
        alu_req         = '0;
        alu_req.warp_id = alu_warp_id;
        alu_req.rd      = alu_rd;
        alu_req.mask    = alu_mask;
        for (int i = 0; i < THREADS_PER_WARP; i++) begin
            alu_req.data[i] = alu_data[i];
        end
    end

    always_comb begin
        mem_req         = '0;
        mem_req.warp_id = mem_warp_id;
        mem_req.rd      = mem_rd;
        mem_req.mask    = mem_mask;
        for (int i = 0; i < THREADS_PER_WARP; i++) begin
            mem_req.data[i] = mem_data[i];
        end
    end

    always_comb begin
        alu_force = alu_valid && (starve_cnt == STARVE_MAX);
        grant_alu = run && alu_valid && (fifo_empty || alu_force);
        grant_mem = run && !fifo_empty && !grant_alu;
        win_req   = grant_alu ? alu_req : fifo_head;
    end

    assign alu_ready = grant_alu;
    assign mem_ready = run && !fifo_full;
    assign mem_push  = mem_valid && mem_ready;

    wb_fifo u_mem_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (mem_push),
        .push_req (mem_req),
        .pop      (grant_mem),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    // Counts consecutive cycles the ALU asked and lost. Saturates so the
    // forced grant stays armed until it is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (grant_alu) begin
            starve_cnt <= '0;
        end else if (run && alu_valid && (starve_cnt != STARVE_MAX)) begin
            starve_cnt <= starve_cnt + STARVE_W'(1);
        end
    end

    // Output register. The enables pulse for one cycle per grant. The fields
    // hold their last granted values between grants.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_write_en     <= 1'b0;
            clear_busy_en   <= 1'b0;
            rd_warp_id      <= '0;
            rd_addr         <= '0;
            rd_thread_mask  <= '0;
            rd_data_q       <= '0;
            clear_busy_warp <= '0;
            clear_busy_reg  <= '0;
            alu_wb_count    <= '0;
            mem_wb_count    <= '0;
        end else begin
            rd_write_en   <= 1'b0;
            clear_busy_en <= 1'b0;
            if (grant_alu || grant_mem) begin
                rd_write_en     <= wb_writes_reg(win_req);
                clear_busy_en   <= 1'b1;
                rd_warp_id      <= win_req.warp_id;
                rd_addr         <= win_req.rd;
                rd_thread_mask  <= win_req.mask;
                rd_data_q       <= win_req.data;
                clear_busy_warp <= win_req.warp_id;
                clear_busy_reg  <= win_req.rd;
            end
            if (grant_alu) begin
                alu_wb_count <= alu_wb_count + 32'd1;
            end
            if (grant_mem) begin
                mem_wb_count <= mem_wb_count + 32'd1;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < THREADS_PER_WARP; i++) begin
            rd_data[i] = rd_data_q[i];
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter. Directed scenarios run first, then a
// randomized phase. Each cycle is checked against a reference model built
// from the arbitration rules: a queue of pending loads and a loss count.
module tb_writeback_arbiter;

    localparam int T     = 32;
    localparam int LIMIT = 4;
    localparam int DW    = T * 32;
    localparam int TW    = 6 + 5 + 32 + DW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                alu_valid, mem_valid;
    logic                alu_ready, mem_ready;
    logic [5:0]          alu_warp_id, mem_warp_id;
    logic [4:0]          alu_rd, mem_rd;
    logic [31:0]         alu_mask, mem_mask;
    logic [T-1:0][31:0]  alu_data, mem_data;
    logic                rd_write_en, clear_busy_en;
    logic [5:0]          rd_warp_id, clear_busy_warp;
    logic [4:0]          rd_addr, clear_busy_reg;
    logic [31:0]         rd_thread_mask;
    logic [T-1:0][31:0]  rd_data;
    logic [31:0]         alu_wb_count, mem_wb_count;

    writeback_arbiter #(
        .THREADS_PER_WARP (T),
        .NUM_WARPS        (32),
        .STARVE_LIMIT     (LIMIT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .alu_valid       (alu_valid),
        .alu_ready       (alu_ready),
        .alu_warp_id     (alu_warp_id),
        .alu_rd          (alu_rd),
        .alu_mask        (alu_mask),
        .alu_data        (alu_data),
        .mem_valid       (mem_valid),
        .mem_ready       (mem_ready),
        .mem_warp_id     (mem_warp_id),
        .mem_rd          (mem_rd),
        .mem_mask        (mem_mask),
        .mem_data        (mem_data),
        .rd_write_en     (rd_write_en),
        .rd_warp_id      (rd_warp_id),
        .rd_addr         (rd_addr),
        .rd_thread_mask  (rd_thread_mask),
        .rd_data         (rd_data),
        .clear_busy_en   (clear_busy_en),
        .clear_busy_warp (clear_busy_warp),
        .clear_busy_reg  (clear_busy_reg),
        .alu_wb_count    (alu_wb_count),
        .mem_wb_count    (mem_wb_count)
    );

    // ---------------- scoreboard / model state ----------------
    int total = 0;
    int bad   = 0;

    logic [TW-1:0] exp_q[$];   // accepted loads not yet written back
    int            losses;     // consecutive cycles the ALU asked and lost
    bit            m_run;      // model: arbiter out of reset and clocked
    logic          e_we, e_cb;
    logic [5:0]    e_warp;
    logic [4:0]    e_rd;
    logic [31:0]   e_mask;
    logic [DW-1:0] e_data;
    logic [31:0]   e_acnt, e_mcnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_data(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        int lane;
        total++;
        assert (obs === exp) else begin
            bad++;
            lane = 0;
            for (int i = T - 1; i >= 0; i--) begin
                if (obs[i*32 +: 32] !== exp[i*32 +: 32]) lane = i;
            end
            $error("FAIL %s lane=%0d observed=%0h expected=%0h", tag, lane,
                   obs[lane*32 +: 32], exp[lane*32 +: 32]);
        end
    endtask

    task automatic check_regs();
        chk("rd_write_en", 64'(rd_write_en), 64'(e_we));
        chk("clear_busy_en", 64'(clear_busy_en), 64'(e_cb));
        chk("rd_warp_id", 64'(rd_warp_id), 64'(e_warp));
        chk("rd_addr", 64'(rd_addr), 64'(e_rd));
        chk("rd_thread_mask", 64'(rd_thread_mask), 64'(e_mask));
        chk("clear_busy_warp", 64'(clear_busy_warp), 64'(e_warp));
        chk("clear_busy_reg", 64'(clear_busy_reg), 64'(e_rd));
        chk("alu_wb_count", 64'(alu_wb_count), 64'(e_acnt));
        chk("mem_wb_count", 64'(mem_wb_count), 64'(e_mcnt));
        chk_data("rd_data", rd_data, e_data);
    endtask

    function automatic void model_clear();
        exp_q.delete();
        losses = 0;
        m_run  = 1'b0;
        e_we   = 1'b0;
        e_cb   = 1'b0;
        e_warp = '0;
        e_rd   = '0;
        e_mask = '0;
        e_data = '0;
        e_acnt = '0;
        e_mcnt = '0;
    endfunction

    function automatic void model_write(input logic [TW-1:0] tx);
        {e_warp, e_rd, e_mask, e_data} = tx;
        e_cb = 1'b1;
        e_we = (e_rd != 5'd0) && (e_mask != 32'd0);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic rand_alu();
        alu_warp_id = 6'($urandom_range(0, 63));
        alu_rd      = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        alu_mask    = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
        for (int i = 0; i < T; i++) alu_data[i] = $urandom;
    endtask

    task automatic rand_mem();
        mem_warp_id = 6'($urandom_range(0, 63));
        mem_rd      = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        mem_mask    = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
        for (int i = 0; i < T; i++) mem_data[i] = $urandom;
    endtask

    // One clock cycle. Drives valids at the falling edge, checks the DUT
    // against the model, then advances the model past the rising edge.
    task automatic step(input logic av, input logic mv, output logic ar_o, output logic mr_o);
        bit mok, hok, awin, mwin;
        logic [TW-1:0] atx, mtx;
        @(negedge clk);
        alu_valid = av;
        mem_valid = mv;
        #1;
        mok  = m_run && (exp_q.size() < 2);
        hok  = m_run && (exp_q.size() > 0);
        awin = m_run && av && (!hok || losses >= LIMIT);
        mwin = hok && !awin;
        ar_o = alu_ready;
        mr_o = mem_ready;
        chk("alu_ready", 64'(alu_ready), 64'(awin));
        chk("mem_ready", 64'(mem_ready), 64'(mok));
        check_regs();
        atx = {alu_warp_id, alu_rd, alu_mask, alu_data};
        mtx = {mem_warp_id, mem_rd, mem_mask, mem_data};
        @(posedge clk);
        #1;
        if (awin) begin
            model_write(atx);
            e_acnt++;
        end else if (mwin) begin
            model_write(exp_q.pop_front());
            e_mcnt++;
        end else begin
            e_we = 1'b0;
            e_cb = 1'b0;
        end
        if (mv && mok) exp_q.push_back(mtx);
        if (awin) losses = 0;
        else if (av && losses < LIMIT) losses++;
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst       = 1'b1;
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        #1;
        model_clear();
        chk("rst_alu_ready", 64'(alu_ready), 64'd0);
        chk("rst_mem_ready", 64'(mem_ready), 64'd0);
        check_regs();
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mem_ready_before_first_edge", 64'(mem_ready), 64'd0);
        check_regs();
        @(posedge clk);
        #1;
        m_run = 1'b1;
        chk("mem_ready_after_first_edge", 64'(mem_ready), 64'd1);
        check_regs();
    endtask

    // ---------------- stimulus ----------------
    logic        ar, mr;
    logic [31:0] lane_word;
    logic        pat_a [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        pat_m [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        rand_alu();
        rand_mem();
        model_clear();
        do_reset(2);

        // ALU-only writeback, lane i carries i.
        alu_warp_id = 6'd3;
        alu_rd      = 5'd7;
        alu_mask    = 32'hFFFF_FFFF;
        for (int i = 0; i < T; i++) alu_data[i] = 32'(i);
        step(1'b1, 1'b0, ar, mr);
        chk("alu_only_ready", 64'(ar), 64'd1);
        lane_word = rd_data[5];
        chk("alu_only_we", 64'(rd_write_en), 64'd1);
        chk("alu_only_addr", 64'(rd_addr), 64'd7);
        chk("alu_only_warp", 64'(rd_warp_id), 64'd3);
        chk("alu_only_lane5", 64'(lane_word), 64'd5);
        chk("alu_only_clear", 64'(clear_busy_en), 64'd1);
        chk("alu_only_count", 64'(alu_wb_count), 64'd1);
        step(1'b0, 1'b0, ar, mr);
        chk("idle_we_drops", 64'(rd_write_en), 64'd0);
        chk("idle_addr_holds", 64'(rd_addr), 64'd7);

        // r0 and zero-mask writebacks release the scoreboard but do not write.
        rand_alu();
        alu_rd   = 5'd0;
        alu_mask = 32'h0000_00FF;
        step(1'b1, 1'b0, ar, mr);
        chk("r0_we", 64'(rd_write_en), 64'd0);
        chk("r0_clear", 64'(clear_busy_en), 64'd1);
        chk("r0_clear_reg", 64'(clear_busy_reg), 64'd0);
        rand_alu();
        alu_rd   = 5'd4;
        alu_mask = 32'd0;
        step(1'b1, 1'b0, ar, mr);
        chk("mask0_we", 64'(rd_write_en), 64'd0);
        chk("mask0_clear", 64'(clear_busy_en), 64'd1);
        chk("mask0_clear_reg", 64'(clear_busy_reg), 64'd4);

        // Both channels busy: MEM wins four times, then the ALU is forced.
        // The forced cycle fills the FIFO, so the next push is refused.
        rand_mem();
        step(1'b0, 1'b1, ar, mr);
        for (int i = 0; i < 7; i++) begin
            rand_alu();
            rand_mem();
            step(1'b1, 1'b1, ar, mr);
            chk($sformatf("starve_grant_%0d", i), 64'(ar), 64'(pat_a[i]));
            chk($sformatf("starve_mready_%0d", i), 64'(mr), 64'(pat_m[i]));
        end
        step(1'b0, 1'b0, ar, mr);
        step(1'b0, 1'b0, ar, mr);

        // Fill the FIFO to two entries, then pulse reset. Nothing may drain.
        do_reset(1);
        rand_mem();
        step(1'b0, 1'b1, ar, mr);
        for (int i = 0; i < 5; i++) begin
            rand_alu();
            rand_mem();
            step(1'b1, 1'b1, ar, mr);
        end
        chk("full_before_reset", 64'(exp_q.size()), 64'd2);
        do_reset(1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, ar, mr);
            chk($sformatf("post_reset_no_write_%0d", i), 64'(rd_write_en | clear_busy_en), 64'd0);
        end

        // Randomized traffic with one mid-stream reset.
        for (int c = 0; c < 400; c++) begin
            if (c == 200) do_reset(1);
            rand_alu();
            rand_mem();
            step(logic'($urandom_range(0, 99) < 60), logic'($urandom_range(0, 99) < 65), ar, mr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
